// File: rtl/oled_frame_arbiter.sv
// Frame-synchronous round-robin arbiter handing a 96x64 RGB565 OLED to one of four renderers.
// Optional macro OLED_ARB_BORDER_EN draws a one-pixel border in the owner's colour.
module oled_frame_arbiter #(
  parameter int          MIN_FRAMES  = 4,
  parameter logic [15:0] IDLE_COLOUR = 16'h0000
) (
  input  logic        clk,
  input  logic        resn,
  input  logic        frame_begin,
  input  logic [12:0] pixel_index,
  input  logic [3:0]  req,
  input  logic [63:0] req_data,
  output logic [15:0] oled_data,
  output logic [3:0]  grant,
  output logic [1:0]  owner_id,
  output logic        switch_pulse
);

  typedef enum logic {S_IDLE = 1'b0, S_OWN = 1'b1} state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_owner, w_owner_nxt;
  logic [1:0]  r_last, w_last_nxt;
  logic [3:0]  r_hold, w_hold_nxt;
  logic [3:0]  r_grant, w_grant_nxt;
  logic        r_switch;
  logic [3:0]  w_others;
  logic [2:0]  w_pick_all;
  logic [2:0]  w_pick_owner;
  logic [2:0]  w_pick_others;
  logic [15:0] w_slice;

  // First requester in mask strictly after 'from', wrapping; 'from' itself is checked last.
  function automatic logic [2:0] rr_pick(input logic [1:0] from, input logic [3:0] mask);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = from + k[1:0];
      if (mask[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign w_others      = req & ~(4'b0001 << r_owner);
  assign w_pick_all    = rr_pick(r_last, req);
  assign w_pick_owner  = rr_pick(r_owner, req);
  assign w_pick_others = rr_pick(r_owner, w_others);

  // Ownership decision, taken only on frame_begin.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_hold_nxt  = r_hold;
    if (frame_begin) begin
      case (r_state)
        S_IDLE: begin
          if (w_pick_all[2]) begin
            w_state_nxt = S_OWN;
            w_owner_nxt = w_pick_all[1:0];
            w_hold_nxt  = 4'd0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_OWN: begin
          if (!req[r_owner]) begin
            w_hold_nxt = 4'd0;
            if (w_pick_owner[2]) begin
              w_owner_nxt = w_pick_owner[1:0];
            end else begin
              w_state_nxt = S_IDLE;
              w_owner_nxt = 2'd0;
            end
          end else if (w_pick_others[2] && (({1'b0, r_hold} + 5'd1) >= 5'(MIN_FRAMES))) begin
            w_owner_nxt = w_pick_others[1:0];
            w_hold_nxt  = 4'd0;
          end else begin
            w_hold_nxt = (r_hold == 4'd15) ? 4'd15 : r_hold + 4'd1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_owner_nxt = 2'd0;
        end
      endcase
      if (w_state_nxt == S_OWN) begin
        w_last_nxt = w_owner_nxt;
      end else begin
        w_last_nxt = r_last;
      end
    end else begin
      w_state_nxt = r_state;
    end
    w_grant_nxt = (w_state_nxt == S_OWN) ? (4'b0001 << w_owner_nxt) : 4'b0000;
  end

  // Arbitration state; last_owner resets to 3 so requester 0 wins first.
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      r_state  <= S_IDLE;
      r_owner  <= 2'd0;
      r_last   <= 2'd3;
      r_hold   <= 4'd0;
      r_grant  <= 4'b0000;
      r_switch <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_last   <= w_last_nxt;
      r_hold   <= w_hold_nxt;
      r_grant  <= w_grant_nxt;
      r_switch <= frame_begin && (w_grant_nxt != r_grant);
    end
  end

  assign grant        = r_grant;
  assign owner_id     = r_owner;
  assign switch_pulse = r_switch;
  assign w_slice      = req_data[{r_owner, 4'b0000} +: 16];

`ifdef OLED_ARB_BORDER_EN
  logic [12:0] w_x, w_y;
  logic        w_border;
  logic [15:0] w_border_colour;

  assign w_x      = pixel_index % 13'd96;
  assign w_y      = pixel_index / 13'd96;
  assign w_border = (w_x == 13'd0) || (w_x == 13'd95) || (w_y == 13'd0) || (w_y == 13'd63);

  // Owner identification colour.
  always_comb begin
    case (r_owner)
      2'd0:    w_border_colour = 16'hF800;
      2'd1:    w_border_colour = 16'h07E0;
      2'd2:    w_border_colour = 16'h001F;
      2'd3:    w_border_colour = 16'hFFE0;
      default: w_border_colour = 16'hF800;
    endcase
  end
`endif

  // Zero-latency pixel mux.
  always_comb begin
    oled_data = IDLE_COLOUR;
    if ((r_state == S_OWN) && (pixel_index < 13'd6144)) begin
`ifdef OLED_ARB_BORDER_EN
      if (w_border) begin
        oled_data = w_border_colour;
      end else begin
        oled_data = w_slice;
      end
`else
      oled_data = w_slice;
`endif
    end else begin
      oled_data = IDLE_COLOUR;
    end
  end

endmodule

// File: tb/tb_oled_frame_arbiter.sv
// Self-checking bench for oled_frame_arbiter: directed table, corner sequences, random vs reference model.
module tb_oled_frame_arbiter;

  localparam int          MINF   = 4;
  localparam logic [15:0] IDLE_C = 16'h0841;
  localparam logic [63:0] RD     = {16'h4444, 16'h3333, 16'h2222, 16'h1111};

  logic        clk = 1'b0;
  logic        resn = 1'b0;
  logic        frame_begin = 1'b0;
  logic [12:0] pixel_index = 13'd0;
  logic [3:0]  req = 4'b0000;
  logic [63:0] req_data = RD;
  logic [15:0] oled_data;
  logic [3:0]  grant;
  logic [1:0]  owner_id;
  logic        switch_pulse;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: owner -1 means idle.
  int m_owner, m_last, m_hold, m_sw;

  oled_frame_arbiter #(.MIN_FRAMES(MINF), .IDLE_COLOUR(IDLE_C)) dut (
    .clk(clk), .resn(resn), .frame_begin(frame_begin), .pixel_index(pixel_index),
    .req(req), .req_data(req_data), .oled_data(oled_data), .grant(grant),
    .owner_id(owner_id), .switch_pulse(switch_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fb;
    logic [3:0]  rq;
    logic [12:0] pix;
    logic [3:0]  g;
    logic [1:0]  id;
    logic        sw;
    logic [15:0] d;
  } vec_t;

  vec_t tbl[16];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr(input int from, input logic [3:0] mask);
    for (int k = 1; k <= 4; k++) begin
      if (mask[(from + k) % 4]) return (from + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_last = 3; m_hold = 0; m_sw = 0;
  endtask

  task automatic model_step(input logic f, input logic [3:0] r);
    int old;
    old  = m_owner;
    m_sw = 0;
    if (f) begin
      if (m_owner < 0) begin
        m_owner = rr(m_last, r);
        m_hold  = 0;
      end else if (!r[m_owner]) begin
        m_owner = rr(m_owner, r);
        m_hold  = 0;
      end else if (((r & ~(4'b0001 << m_owner)) != 4'b0000) && (m_hold + 1 >= MINF)) begin
        m_owner = rr(m_owner, r & ~(4'b0001 << m_owner));
        m_hold  = 0;
      end else begin
        m_hold = (m_hold + 1 > 15) ? 15 : m_hold + 1;
      end
      if (m_owner >= 0) m_last = m_owner;
      m_sw = (m_owner != old) ? 1 : 0;
    end
  endtask

  function automatic logic [15:0] exp_pixel();
    int x, y;
    logic [15:0] cols[4];
    cols = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFE0};
    x = int'(pixel_index) % 96;
    y = int'(pixel_index) / 96;
    if (m_owner < 0 || pixel_index >= 13'd6144) return IDLE_C;
`ifdef OLED_ARB_BORDER_EN
    if (x == 0 || x == 95 || y == 0 || y == 63) return cols[m_owner];
`endif
    return req_data[m_owner*16 +: 16];
  endfunction

  task automatic check_model(input string tag);
    logic [3:0] eg;
    logic [1:0] eid;
    eg  = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    eid = (m_owner < 0) ? 2'd0 : 2'(m_owner);
    check({tag, ".grant"}, {12'd0, grant}, {12'd0, eg});
    check({tag, ".owner_id"}, {14'd0, owner_id}, {14'd0, eid});
    check({tag, ".switch"}, {15'd0, switch_pulse}, {15'd0, 1'(m_sw)});
    check({tag, ".data"}, oled_data, exp_pixel());
  endtask

  task automatic tick(input string tag, input logic f, input logic [3:0] r,
                      input logic [12:0] p, input logic [63:0] d);
    frame_begin = f; req = r; pixel_index = p; req_data = d;
    @(posedge clk);
    model_step(f, r);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    resn = 1'b0; frame_begin = 1'b0; req = 4'b0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1 resn = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{1'b0, 4'b0100, 13'd100,  4'b0000, 2'd0, 1'b0, IDLE_C};
    tbl[1]  = '{1'b1, 4'b0100, 13'd100,  4'b0100, 2'd2, 1'b1, 16'h3333};
    tbl[2]  = '{1'b0, 4'b0100, 13'd100,  4'b0100, 2'd2, 1'b0, 16'h3333};
    tbl[3]  = '{1'b1, 4'b0000, 13'd200,  4'b0000, 2'd0, 1'b1, IDLE_C};
    tbl[4]  = '{1'b1, 4'b1111, 13'd200,  4'b1000, 2'd3, 1'b1, 16'h4444};
    tbl[5]  = '{1'b0, 4'b0000, 13'd200,  4'b1000, 2'd3, 1'b0, 16'h4444};
    tbl[6]  = '{1'b1, 4'b0000, 13'd200,  4'b0000, 2'd0, 1'b1, IDLE_C};
    tbl[7]  = '{1'b1, 4'b1111, 13'd200,  4'b0001, 2'd0, 1'b1, 16'h1111};
    tbl[8]  = '{1'b1, 4'b0011, 13'd200,  4'b0001, 2'd0, 1'b0, 16'h1111};
    tbl[9]  = '{1'b0, 4'b0011, 13'd200,  4'b0001, 2'd0, 1'b0, 16'h1111};
    tbl[10] = '{1'b1, 4'b0011, 13'd200,  4'b0001, 2'd0, 1'b0, 16'h1111};
    tbl[11] = '{1'b1, 4'b0011, 13'd200,  4'b0001, 2'd0, 1'b0, 16'h1111};
    tbl[12] = '{1'b1, 4'b0011, 13'd200,  4'b0010, 2'd1, 1'b1, 16'h2222};
    tbl[13] = '{1'b0, 4'b1001, 13'd6000, 4'b0010, 2'd1, 1'b0, 16'h2222};
    tbl[14] = '{1'b1, 4'b1001, 13'd6000, 4'b1000, 2'd3, 1'b1, 16'h4444};
    tbl[15] = '{1'b0, 4'b1001, 13'd6144, 4'b1000, 2'd3, 1'b0, IDLE_C};

    // Reset state.
    resn = 1'b0;
    #3;
    check("rst.grant", {12'd0, grant}, 16'd0);
    check("rst.owner_id", {14'd0, owner_id}, 16'd0);
    check("rst.switch", {15'd0, switch_pulse}, 16'd0);
    check("rst.data", oled_data, IDLE_C);
    do_reset();

    // Directed table.
    for (int i = 0; i < 16; i++) begin
      frame_begin = tbl[i].fb; req = tbl[i].rq; pixel_index = tbl[i].pix; req_data = RD;
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d.grant", i), {12'd0, grant}, {12'd0, tbl[i].g});
      check($sformatf("tbl%0d.owner_id", i), {14'd0, owner_id}, {14'd0, tbl[i].id});
      check($sformatf("tbl%0d.switch", i), {15'd0, switch_pulse}, {15'd0, tbl[i].sw});
      check($sformatf("tbl%0d.data", i), oled_data, tbl[i].d);
    end

    // Mid-frame reset while owning 2; regrant waits for the next frame_begin.
    do_reset();
    tick("r33a", 1'b1, 4'b0100, 13'd300, RD);
    tick("r33b", 1'b0, 4'b0100, 13'd300, RD);
    resn = 1'b0;
    model_reset();
    #1;
    check("r33.rst_grant", {12'd0, grant}, 16'd0);
    check("r33.rst_data", oled_data, IDLE_C);
    #1 resn = 1'b1;
    for (int i = 0; i < 3; i++) tick("r33c", 1'b0, 4'b0100, 13'd300, RD);
    tick("r33d", 1'b1, 4'b0100, 13'd300, RD);
    check("r33.regrant", {12'd0, grant}, 16'h0004);

    // Long uncontested ownership, then contention: hold count must saturate, not wrap.
    do_reset();
    tick("sat0", 1'b1, 4'b0001, 13'd300, RD);
    for (int i = 0; i < 18; i++) tick("sat1", 1'b1, 4'b0001, 13'd300, RD);
    tick("sat2", 1'b1, 4'b0101, 13'd300, RD);
    check("sat.rotate", {12'd0, grant}, 16'h0004);

    // Randomised run against the reference model.
    do_reset();
    begin
      logic [3:0] r_cur;
      r_cur = 4'b0000;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 7) == 0) r_cur = 4'($urandom);
        if ($urandom_range(0, 299) == 0) begin
          resn = 1'b0;
          model_reset();
          #1;
          check("rand.rst_grant", {12'd0, grant}, 16'd0);
          #1 resn = 1'b1;
        end
        tick("rand", ($urandom_range(0, 3) == 0), r_cur, 13'($urandom),
             {$urandom, $urandom});
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/oled_frame_arbiter.md
OLED_FRAME_ARBITER -- requirements
Module: oled_frame_arbiter

Interface
REQ-001 SHALL have parameter MIN_FRAMES, default 4, meaning the minimum number of whole frames a contested owner holds the display (range 1..15).
REQ-002 SHALL have parameter IDLE_COLOUR, default 16'h0000, meaning the RGB565 value driven when no requester owns the display.
REQ-003 SHALL have port clk  input  1  single clock, the OLED pixel clock domain.
REQ-004 SHALL have port resn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port frame_begin  input  1  one-cycle pulse from the OLED driver at the start of each frame.
REQ-006 SHALL have port pixel_index  input  13  current pixel index (0..6143, 96x64 raster).
REQ-007 SHALL have port req  input  4  per-renderer display request, level-sensitive.
REQ-008 SHALL have port req_data  input  64  four RGB565 pixel values; renderer i at bits [16i+15:16i].
REQ-009 SHALL have port oled_data  output  16  pixel value to the OLED driver.
REQ-010 SHALL have port grant  output  4  one-hot owner indication; all zero when idle.
REQ-011 SHALL have port owner_id  output  2  binary index of the current owner; 0 when idle.
REQ-012 SHALL have port switch_pulse  output  1  one-cycle pulse on every change of grant.

Function
REQ-013 SHALL implement two states: IDLE (no owner) and OWN (one owner).
REQ-014 SHALL evaluate ownership only in cycles where frame_begin=1; grant, owner_id and state SHALL be stable between frame_begin pulses.
REQ-015 SHALL register decisions so that grant changes on the clock edge that samples frame_begin and is visible the following cycle.
REQ-016 SHALL sample req in the same cycle as frame_begin; a req rising in that cycle counts.
REQ-017 IDLE + frame_begin + any req: go to OWN, choose the round-robin winner from the requester after last_owner (wrapping 3->0), clear hold_cnt.
REQ-018 IDLE + frame_begin + no req: stay IDLE.
REQ-019 OWN + frame_begin + owner req=0: hand over to the round-robin winner after the owner, or go to IDLE if no req is set; clear hold_cnt.
REQ-020 OWN + frame_begin + owner req=1 + other req set + hold_cnt+1 >= MIN_FRAMES: rotate to the next round-robin requester and clear hold_cnt.
REQ-021 In all other OWN + frame_begin cases, the owner SHALL be kept and hold_cnt SHALL increment, saturating at 15.
REQ-022 last_owner SHALL be updated to the owner on every grant, and SHALL be retained through IDLE.
REQ-023 switch_pulse SHALL be 1 for exactly one cycle, aligned with the first cycle of a new grant value (including OWN->IDLE).
REQ-024 oled_data SHALL be a combinational mux: IDLE gives IDLE_COLOUR; OWN gives the owner's req_data slice for the current pixel_index (zero latency).
REQ-025 pixel_index values >= 6144 SHALL produce IDLE_COLOUR.

Reset
REQ-026 On resn=0, asynchronously: state=IDLE, grant=4'b0000, owner_id=0, switch_pulse=0, hold_cnt=0, last_owner=3 (first winner is requester 0), oled_data=IDLE_COLOUR.
REQ-027 A reset mid-frame SHALL take effect immediately; after release, the first grant SHALL wait for the next frame_begin.

Configuration
REQ-028 Macro OLED_ARB_BORDER_EN: when defined, while in OLED, pixels with x=0, x=95, y=0 or y=63 (x=pixel_index mod 96, y=pixel_index/96) SHALL output the owner colour {16'hF800, 16'h07E0, 16'h001F, 16'hFFE0}[owner_id]; when undefined, no border logic SHALL exist and REQ-024 applies to all pixels.

Verification
REQ-029 After reset, req=4'b0100, one frame_begin -> next cycle grant=4'b0100, owner_id=2, switch_pulse=1 for 1 cycle, oled_data=req_data[47:32].
REQ-030 MIN_FRAMES=4, owner 0, req=4'b0011 held -> grant stays 4'b0001 for frame_begins 1-3, moves to 4'b0010 on the 4th.
REQ-031 Owner 1 drops req mid-frame, req=4'b1001 -> grant unchanged until the next frame_begin, then 4'b1000 (round-robin after 1 skips 2).
REQ-032 All req dropped while owning 3 -> at frame_begin grant=0, oled_data=IDLE_COLOUR, switch_pulse=1; a later req=4'b1111 grants requester 0.
REQ-033 resn pulsed low mid-frame while owning 2 -> grant=0 immediately; with req=4'b0100 held, regrant occurs only at the next frame_begin.
REQ-034 With OLED_ARB_BORDER_EN and owner 1: pixel_index 0, 95, 6048, 6143 -> 16'h07E0; pixel_index 97 -> req_data[31:16].
